// File: rtl/rv_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv_test_ctrl
//  Description : Test harness controller for a RISC-V core. It streams a
//                program image into memory and presets the register file
//                (x2 = SP_INIT, x3 = GP_INIT, all others 0). It then releases
//                the core from reset and runs it until a tohost store or a
//                cycle timeout ends the run.
//                Optional feature macro: RV_TEST_CTRL_TOHOST_EN
//                  defined   -> a store to TOHOST_ADDR ends the run and sets
//                               pass to (store data == 1).
//                  undefined -> the st_* ports are ignored and the run ends
//                               only by timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_test_ctrl #(
    parameter int                XLEN        = 64,
    parameter int                REGS        = 32,
    parameter int                MEM_WORDS   = 5000,
    parameter int                RUN_CYCLES  = 4000,
    parameter logic [XLEN-1:0]   SP_INIT     = 64'h7ffffff0,
    parameter logic [XLEN-1:0]   GP_INIT     = 64'h10000000,
    parameter logic [XLEN-1:0]   TOHOST_ADDR = 64'h80001000,
    localparam int               AW          = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic            ld_last,
    input  logic [XLEN-1:0] ld_data,

    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,

    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wdata,

    output logic            core_rst_n,

    input  logic            st_valid,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,

    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic            overflow,
    output logic [31:0]     cycle_count
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_PRESET = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_last_idx = AW'(MEM_WORDS - 1);
    localparam logic [4:0]    c_last_rf  = 5'(REGS - 1);
    localparam logic [31:0]   c_last_cyc = 32'(RUN_CYCLES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_armed;
    logic [AW-1:0]   r_idx;
    logic [4:0]      r_rf_idx;
    logic [31:0]     r_cycles;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;
    logic            r_overflow;

    logic            w_accept;
    logic            w_rf_last;
    logic            w_st_hit;
    logic            w_tohost_hit;
    logic            w_tohost_pass;
    logic            w_fin_overflow;
    logic            w_fin_timeout;
    logic            w_fin_tohost;

    // A word is taken only once the controller is armed, which keeps ld_ready low during reset
    assign w_accept  = ld_valid && r_armed && (r_state == S_LOAD);
    assign w_rf_last = (r_rf_idx == c_last_rf);
    assign w_st_hit  = st_valid && (st_addr == TOHOST_ADDR);

`ifdef RV_TEST_CTRL_TOHOST_EN
    assign w_tohost_hit  = w_st_hit;
    assign w_tohost_pass = (st_data == XLEN'(1));
`else
    // Store monitor is present but has no effect in this build
    logic w_unused_st;
    assign w_unused_st   = w_st_hit ^ (^st_data);
    assign w_tohost_hit  = 1'b0;
    assign w_tohost_pass = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, handshake and write enables, run-end events
    always_comb begin
        w_next_state   = r_state;
        ld_ready       = 1'b0;
        mem_we         = 1'b0;
        rf_we          = 1'b0;
        core_rst_n     = 1'b0;
        w_fin_overflow = 1'b0;
        w_fin_timeout  = 1'b0;
        w_fin_tohost   = 1'b0;
        case (r_state)
            S_LOAD: begin
                ld_ready = r_armed;
                mem_we   = w_accept;
                if (w_accept) begin
                    if (ld_last) begin
                        w_next_state = S_PRESET;
                    end else if (r_idx == c_last_idx) begin
                        // Memory full without a final word: stop, never wrap
                        w_next_state   = S_DONE;
                        w_fin_overflow = 1'b1;
                    end
                end
            end
            S_PRESET: begin
                rf_we = 1'b1;
                if (w_rf_last) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                core_rst_n = 1'b1;
                // A tohost store in the final cycle takes precedence over timeout
                if (w_tohost_hit) begin
                    w_next_state = S_DONE;
                    w_fin_tohost = 1'b1;
                end else if (r_cycles == c_last_cyc) begin
                    w_next_state  = S_DONE;
                    w_fin_timeout = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_DONE;
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // Arm the load port on the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Image word index; holds at the last slot on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept && !ld_last && (r_idx != c_last_idx)) begin
            r_idx <= r_idx + AW'(1);
        end
    end

    // Register-file preset index, stepping through x0..x(REGS-1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_idx <= '0;
        end else if ((r_state == S_PRESET) && !w_rf_last) begin
            r_rf_idx <= r_rf_idx + 5'd1;
        end
    end

    // Core cycle counter: counts every RUN cycle, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if ((r_state == S_RUN) && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Run status, latched on the single transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_fin_overflow || w_fin_timeout || w_fin_tohost) begin
            r_done     <= 1'b1;
            r_pass     <= w_fin_tohost && w_tohost_pass;
            r_timeout  <= w_fin_timeout;
            r_overflow <= w_fin_overflow;
        end
    end

    // Preset value for the register currently being written
    always_comb begin
        rf_wdata = '0;
        if (r_rf_idx == 5'd2) begin
            rf_wdata = SP_INIT;
        end else if (r_rf_idx == 5'd3) begin
            rf_wdata = GP_INIT;
        end
    end

    assign mem_addr    = r_idx;
    assign mem_wdata   = ld_data;
    assign rf_addr     = r_rf_idx;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign cycle_count = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_rv_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_test_ctrl
//  Description : Scoreboard bench for rv_test_ctrl. Expected memory writes,
//                register presets and run status are queued as stimulus is
//                issued; a negedge monitor pops and compares them.
//                Honours RV_TEST_CTRL_TOHOST_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_test_ctrl;

    localparam int          XLEN       = 64;
    localparam int          REGS       = 32;
    localparam int          MEM_WORDS  = 40;
    localparam int          RUN_CYCLES = 150;
    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [63:0] SP         = 64'h7ffffff0;
    localparam logic [63:0] GP         = 64'h10000000;
    localparam logic [63:0] TOHOST     = 64'h80001000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic            ld_last = 1'b0;
    logic [XLEN-1:0] ld_data = '0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_wdata;
    logic            core_rst_n;
    logic            st_valid = 1'b0;
    logic [XLEN-1:0] st_addr = '0;
    logic [XLEN-1:0] st_data = '0;
    logic            done, pass, timeout, overflow;
    logic [31:0]     cycle_count;

    rv_test_ctrl #(
        .XLEN(XLEN), .REGS(REGS), .MEM_WORDS(MEM_WORDS), .RUN_CYCLES(RUN_CYCLES),
        .SP_INIT(SP), .GP_INIT(GP), .TOHOST_ADDR(TOHOST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .core_rst_n(core_rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(done), .pass(pass), .timeout(timeout), .overflow(overflow),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [63:0] data; } mem_exp_t;
    typedef struct packed { logic [4:0] addr; logic [63:0] data; } rf_exp_t;
    typedef struct packed { logic pass; logic timeout; logic overflow; logic [31:0] cnt; } st_exp_t;

    mem_exp_t q_mem[$];
    rf_exp_t  q_rf[$];
    st_exp_t  q_st[$];
    int       n_vec = 0;
    int       n_err = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference outcome of a run from the store cycle k (k<0: no store) and data
    function automatic st_exp_t model_run(input int k, input logic [63:0] d);
        st_exp_t s;
        s.overflow = 1'b0;
`ifdef RV_TEST_CTRL_TOHOST_EN
        if (k >= 0 && k <= RUN_CYCLES - 1) begin
            s.pass    = (d == 64'd1);
            s.timeout = 1'b0;
            s.cnt     = 32'(k + 1);
            return s;
        end
`endif
        s.pass    = 1'b0;
        s.timeout = 1'b1;
        s.cnt     = 32'(RUN_CYCLES);
        return s;
    endfunction

    function automatic logic [63:0] preset_value(input int r);
        if (r == 2) return SP;
        if (r == 3) return GP;
        return 64'd0;
    endfunction

    // Monitor: compare every DUT write and every run completion with the queues
    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        mem_exp_t me;
        rf_exp_t  re;
        st_exp_t  se;
        if (mem_we === 1'b1) begin
            if (q_mem.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_mem_write: got addr %0d, expected no write", mem_addr);
            end else begin
                me = q_mem.pop_front();
                check64("mem_addr", 64'(mem_addr), 64'(me.addr));
                check64("mem_wdata", mem_wdata, me.data);
            end
        end
        if (rf_we === 1'b1) begin
            if (q_rf.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_rf_write: got addr %0d, expected no write", rf_addr);
            end else begin
                re = q_rf.pop_front();
                check64("rf_addr", 64'(rf_addr), 64'(re.addr));
                check64("rf_wdata", rf_wdata, re.data);
            end
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (q_st.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: got done=1, expected 0");
            end else begin
                se = q_st.pop_front();
                check64("status_pass", 64'(pass), 64'(se.pass));
                check64("status_timeout", 64'(timeout), 64'(se.timeout));
                check64("status_overflow", 64'(overflow), 64'(se.overflow));
                check64("status_cycle_count", 64'(cycle_count), 64'(se.cnt));
            end
        end
        prev_done = done;
    end

    // Reset pulse; leaves the caller 1 time unit after a rising edge
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        st_valid = 1'b0;
        #1;
        check64("reset_outputs",
                64'({ld_ready, mem_we, rf_we, core_rst_n, done, pass, timeout, overflow}), 64'd0);
        check64("reset_cycle_count", 64'(cycle_count), 64'd0);
        q_mem.delete();
        q_rf.delete();
        q_st.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offer one word until it is accepted or the bound expires
    task automatic send_word(input logic [63:0] data, input logic last, output bit ok);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        ok       = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic load_image(input int n, input bit with_last, output int accepted);
        logic [63:0] w;
        bit ok;
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (i < MEM_WORDS) q_mem.push_back({AW'(i), w});
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            send_word(w, with_last && (i == n - 1), ok);
            if (!ok) break;
            accepted++;
        end
    endtask

    task automatic run_test(input int n, input bit with_last, input int k,
                            input logic [63:0] d, input bit decoy);
        st_exp_t s;
        int      acc;
        bit      seen;
        if (with_last) begin
            for (int r = 0; r < REGS; r++) q_rf.push_back({5'(r), preset_value(r)});
            s = model_run(k, d);
        end else begin
            s = '{pass: 1'b0, timeout: 1'b0, overflow: 1'b1, cnt: 32'd0};
        end
        q_st.push_back(s);
        load_image(n, with_last, acc);
        if (!with_last) begin
            check64("overflow_accepts", 64'(acc), 64'(MEM_WORDS));
            check64("overflow_ld_ready", 64'(ld_ready), 64'd0);
            check64("overflow_core_rst_n", 64'(core_rst_n), 64'd0);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (core_rst_n === 1'b1) seen = 1'b1;
            end
            check64("core_release", 64'(seen), 64'd1);
            check64("run_start_count", 64'(cycle_count), 64'd0);
            if (k >= 0) begin
                for (int c = 0; c < k; c++) begin
                    if (decoy && c == k / 2) begin
                        st_valid = 1'b1; st_addr = TOHOST + 64'd8; st_data = 64'd1;
                    end
                    @(negedge clk);
                    st_valid = 1'b0;
                end
                st_valid = 1'b1; st_addr = TOHOST; st_data = d;
                @(negedge clk);
                st_valid = 1'b0;
            end
        end
        seen = (done === 1'b1);
        for (int c = 0; c < RUN_CYCLES + 20 && !seen; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check64("done_reached", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        check64("done_hold", 64'({done, core_rst_n, mem_we, rf_we, ld_ready}), 64'b10000);
        check64("hold_cycle_count", 64'(cycle_count), 64'(s.cnt));
        check64("mem_queue_drained", 64'(q_mem.size()), 64'd0);
        check64("rf_queue_drained", 64'(q_rf.size()), 64'd0);
        check64("status_queue_drained", 64'(q_st.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Reset during register preset: progress is discarded immediately
    task automatic preset_reset_test();
        int acc;
        bit seen;
        for (int r = 0; r < REGS; r++) q_rf.push_back({5'(r), preset_value(r)});
        load_image(35, 1'b1, acc);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (rf_we === 1'b1 && rf_addr == 5'd10) seen = 1'b1;
        end
        check64("preset_reached_x10", 64'(seen), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check64("preset_reset_outputs", 64'({rf_we, mem_we, ld_ready, core_rst_n, done}), 64'd0);
        q_mem.delete();
        q_rf.delete();
        q_st.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_test(35, 1'b1, int'($urandom_range(0, RUN_CYCLES - 1)), 64'd1, 1'b0);
    endtask

    initial begin : main
        int          n;
        int          k;
        logic [63:0] d;
        do_reset();
        run_test(35, 1'b1, 100, 64'd1, 1'b0);
        do_reset();
        run_test(20, 1'b1, int'($urandom_range(10, 140)), 64'd3, 1'b1);
        do_reset();
        run_test(35, 1'b1, RUN_CYCLES - 1, 64'd1, 1'b0);
        do_reset();
        run_test(12, 1'b1, -1, 64'd0, 1'b0);
        do_reset();
        run_test(45, 1'b0, -1, 64'd0, 1'b0);
        do_reset();
        preset_reset_test();
        do_reset();
        run_test(MEM_WORDS, 1'b1, int'($urandom_range(0, RUN_CYCLES - 1)), 64'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n = int'($urandom_range(1, MEM_WORDS));
            k = int'($urandom_range(0, RUN_CYCLES + 10));
            d = ($urandom_range(0, 1) == 1) ? 64'd1 : {$urandom, $urandom};
            do_reset();
            run_test(n, 1'b1, k, d, 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
